// File: rtl/sram_read_sequencer.sv
// rtl/sram_read_sequencer.sv - 2-D strided SRAM read job sequencer
// Walks a rows x cols window and streams the returned words through a 2-entry buffer.
module sram_read_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_row_stride,
  input  logic [ADDR_WIDTH-1:0] i_num_cols,
  input  logic [ADDR_WIDTH-1:0] i_num_rows,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_sram_read_en,
  output logic [ADDR_WIDTH-1:0] o_sram_read_addr,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  input  logic                  i_sram_data_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] num_cols_q;
  logic [ADDR_WIDTH-1:0] num_rows_q;
  logic [ADDR_WIDTH-1:0] row_ptr_q;
  logic [ADDR_WIDTH-1:0] col_q;
  logic [ADDR_WIDTH-1:0] row_q;
  logic                  inflight_q;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] fifo_mem_q [2];
  logic                  fifo_rd_q;
  logic                  fifo_wr_q;
  logic [1:0]            fifo_count_q;

  logic       accept;
  logic       job_empty;
  logic       pop;
  logic       push;
  logic       last_col;
  logic       last_elem;
  logic       read_en;
  logic       drained;
  logic [2:0] fill_after;

  assign accept    = (state_q == ST_IDLE) && i_start;
  assign job_empty = (i_num_cols == '0) || (i_num_rows == '0);
  assign pop       = o_data_valid && i_data_ready;
  // Only a return for a read we actually issued is buffered; stale returns after reset are dropped.
  assign push      = i_sram_data_valid && inflight_q;

  // Occupancy the buffer would reach if the in-flight return lands and the head pops now.
  assign fill_after = {1'b0, fifo_count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign read_en    = (state_q == ST_ISSUE) && (fill_after < 3'd2);
  assign last_col   = (col_q == num_cols_q - ADDR_WIDTH'(1));
  assign last_elem  = last_col && (row_q == num_rows_q - ADDR_WIDTH'(1));
  assign drained    = !inflight_q && (fill_after == 3'd0);

  assign o_sram_read_addr = row_ptr_q + col_q;
  assign o_data           = fifo_mem_q[fifo_rd_q];
  assign o_data_valid     = (fifo_count_q != 2'd0);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = job_empty ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE: if (read_en && last_elem) state_d = ST_DRAIN;
      ST_DRAIN: if (done_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy         = (state_q != ST_IDLE);
    o_done         = done_q;
    o_sram_read_en = read_en;
  end

  // Row pointer advances by the stride at each row wrap, so no multiply is needed.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      stride_q   <= '0;
      num_cols_q <= '0;
      num_rows_q <= '0;
      row_ptr_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= read_en;
      done_q     <= (accept && job_empty) ||
                    ((state_q == ST_DRAIN) && !done_q && drained);
      if (accept) begin
        stride_q   <= i_row_stride;
        num_cols_q <= i_num_cols;
        num_rows_q <= i_num_rows;
        row_ptr_q  <= i_base_addr;
        col_q      <= '0;
        row_q      <= '0;
      end else if (read_en) begin
        if (last_col) begin
          col_q     <= '0;
          row_q     <= row_q + ADDR_WIDTH'(1);
          row_ptr_q <= row_ptr_q + stride_q;
        end else begin
          col_q <= col_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_rd_q     <= 1'b0;
      fifo_wr_q     <= 1'b0;
      fifo_count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem_q[fifo_wr_q] <= i_sram_data;
        fifo_wr_q             <= ~fifo_wr_q;
      end
      if (pop) begin
        fifo_rd_q <= ~fifo_rd_q;
      end
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
        2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

endmodule
